// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory responder with wait states, RAM and LEDR/SW/KEY I/O window
module data_mem_responder #(
   parameter int          ADDR_W      = 12,
   parameter int          WAIT_CYCLES = 1,
   parameter logic [15:0] MMIO_BASE   = 16'hFF00
) (
   input  logic        Clock,
   input  logic        Reset,
   input  logic [15:0] Addr,
   input  logic [15:0] WrData,
   input  logic        Write,
   input  logic        Read,
   output logic [15:0] RdData,
   output logic        Waitreq,
   input  logic [9:0]  SW,
   input  logic [3:0]  KEY,
   output logic [9:0]  LEDR,
   output logic        Error
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam logic [16:0] RAM_WORDS = 17'd1 << ADDR_W;
   localparam logic [3:0]  WAIT_CNT  = 4'(WAIT_CYCLES);
   localparam logic [15:0] SW_ADDR   = MMIO_BASE + 16'd1;
   localparam logic [15:0] KEY_ADDR  = MMIO_BASE + 16'd2;

   state_t             state_q;
   logic [3:0]         cnt_q;
   logic [15:0]        addr_q;
   logic [15:0]        wrdata_q;
   logic               op_wr_q;
   logic [15:0]        rddata_q;
   logic [9:0]         ledr_q;
   logic               error_q;
   logic [15:0]        mem_q [0:(1 << ADDR_W) - 1];

   logic               req;
   logic               commit;
   logic               is_ram;
   logic               is_led;
   logic [ADDR_W-1:0]  ram_idx;
   logic [15:0]        rd_val_d;

   assign req     = Read | Write;
   // The processor is released only in DONE; with no request the bus never stalls.
   assign Waitreq = req && (state_q != DONE);
   assign commit  = (state_q == BUSY) && req && (cnt_q == 4'd0);

   assign is_ram  = ({1'b0, addr_q} < RAM_WORDS);
   assign is_led  = (addr_q == MMIO_BASE);
   assign ram_idx = addr_q[ADDR_W-1:0];

   assign RdData  = rddata_q;
   assign LEDR    = ledr_q;
   assign Error   = error_q;

   // Read-data selection from the latched address.
   always_comb begin
      rd_val_d = 16'h0000;
      if (is_ram) begin
         rd_val_d = mem_q[ram_idx];
      end else if (is_led) begin
         rd_val_d = {6'b0, ledr_q};
      end else if (addr_q == SW_ADDR) begin
         rd_val_d = {6'b0, SW};
      end else if (addr_q == KEY_ADDR) begin
         rd_val_d = {12'b0, KEY};
      end
   end

   // RAM write port; contents survive reset, but a reset edge blocks the commit.
   always_ff @(posedge Clock) begin
      if (!Reset && commit && op_wr_q && is_ram) begin
         mem_q[ram_idx] <= wrdata_q;
      end
   end

   // Transfer FSM: latch in IDLE, count wait states in BUSY, release in DONE.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q  <= IDLE;
         cnt_q    <= 4'd0;
         addr_q   <= 16'h0000;
         wrdata_q <= 16'h0000;
         op_wr_q  <= 1'b0;
         rddata_q <= 16'h0000;
         ledr_q   <= 10'h000;
         error_q  <= 1'b0;
      end else begin
         if (Read && Write) begin
            error_q <= 1'b1;
         end
         case (state_q)
            IDLE: begin
               if (req) begin
                  addr_q   <= Addr;
                  wrdata_q <= WrData;
                  op_wr_q  <= Write;
                  cnt_q    <= WAIT_CNT;
                  state_q  <= BUSY;
               end
            end
            BUSY: begin
               if (!req) begin
                  state_q <= IDLE;
               end else if (cnt_q == 4'd0) begin
                  if (op_wr_q) begin
                     if (is_led) begin
                        ledr_q <= wrdata_q[9:0];
                     end
                  end else begin
                     rddata_q <= rd_val_d;
                  end
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            DONE:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed bench with transaction-level reference model
module tb_data_mem_responder;

   localparam int WA = 1;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic [9:0]  SW    = 10'h000;
   logic [3:0]  KEY   = 4'h0;

   logic [15:0] Addr = '0, WrData = '0;
   logic        Read = 1'b0, Write = 1'b0;
   logic [15:0] RdData;
   logic        Waitreq, Error;
   logic [9:0]  LEDR;

   logic [15:0] Addr0 = '0, WrData0 = '0;
   logic        Read0 = 1'b0, Write0 = 1'b0;
   logic [15:0] RdData0;
   logic        Waitreq0, Error0;
   logic [9:0]  LEDR0;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   always #5 Clock = ~Clock;

   data_mem_responder #(.ADDR_W(12), .WAIT_CYCLES(WA), .MMIO_BASE(16'hFF00)) dut (
      .Clock(Clock), .Reset(Reset), .Addr(Addr), .WrData(WrData), .Write(Write),
      .Read(Read), .RdData(RdData), .Waitreq(Waitreq), .SW(SW), .KEY(KEY),
      .LEDR(LEDR), .Error(Error)
   );

   data_mem_responder #(.ADDR_W(12), .WAIT_CYCLES(0), .MMIO_BASE(16'hFF00)) dut0 (
      .Clock(Clock), .Reset(Reset), .Addr(Addr0), .WrData(WrData0), .Write(Write0),
      .Read(Read0), .RdData(RdData0), .Waitreq(Waitreq0), .SW(SW), .KEY(KEY),
      .LEDR(LEDR0), .Error(Error0)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a transfer is a sequence of cycle positions 0..WA+2; the
   // access happens at the end of position WA+1 and position WA+2 is the release.
   logic [15:0] m_mem [0:4095];
   bit          m_busy = 1'b0;
   int          m_pos  = 0;
   logic [15:0] m_addr, m_data;
   bit          m_wr;
   logic [15:0] m_rd   = '0;
   logic [9:0]  m_led  = '0;
   bit          m_err  = 1'b0;

   always @(posedge Clock) begin
      if (Reset) begin
         m_busy = 1'b0;
         m_rd   = '0;
         m_led  = '0;
         m_err  = 1'b0;
      end else begin
         if (Read && Write) m_err = 1'b1;
         if (!m_busy) begin
            if (Read || Write) begin
               m_busy = 1'b1;
               m_pos  = 1;
               m_addr = Addr;
               m_data = WrData;
               m_wr   = Write;
            end
         end else if (m_pos == WA + 2 || !(Read || Write)) begin
            m_busy = 1'b0;
         end else begin
            if (m_pos == WA + 1) begin
               if (m_wr) begin
                  if (m_addr < 16'd4096) m_mem[m_addr[11:0]] = m_data;
                  else if (m_addr == 16'hFF00) m_led = m_data[9:0];
               end else begin
                  if (m_addr < 16'd4096)      m_rd = m_mem[m_addr[11:0]];
                  else if (m_addr == 16'hFF00) m_rd = {6'b0, m_led};
                  else if (m_addr == 16'hFF01) m_rd = {6'b0, SW};
                  else if (m_addr == 16'hFF02) m_rd = {12'b0, KEY};
                  else                         m_rd = 16'h0000;
               end
            end
            m_pos++;
         end
      end
   end

   // Per-cycle comparison of the main instance against the model.
   always @(negedge Clock) begin
      if (chk_en) begin
         chk("waitreq", {31'b0, Waitreq},
             {31'b0, (Read || Write) && !(m_busy && m_pos == WA + 2)});
         chk("rddata", {16'b0, RdData}, {16'b0, m_rd});
         chk("ledr", {22'b0, LEDR}, {22'b0, m_led});
         chk("error", {31'b0, Error}, {31'b0, m_err});
      end
   end

   task automatic xfer(input bit s, input logic [15:0] a, input logic [15:0] d,
                       input bit rd, input bit wr, output logic [15:0] q, output int w);
      bit done;
      done = 1'b0;
      w = 0;
      q = '0;
      if (!s) begin
         Addr = a; WrData = d; Read = rd; Write = wr;
      end else begin
         Addr0 = a; WrData0 = d; Read0 = rd; Write0 = wr;
      end
      for (int i = 0; i < 40 && !done; i++) begin
         @(negedge Clock);
         if ((s ? Waitreq0 : Waitreq) == 1'b0) begin
            done = 1'b1;
            q = s ? RdData0 : RdData;
         end else begin
            w++;
         end
      end
      if (!done) begin
         n_chk++;
         n_fail++;
         $display("FAIL xfer_timeout: got no release within 40 cycles, expected release (addr %h)", a);
      end
      @(posedge Clock); #1;
   endtask

   task automatic idle(input int n);
      Read = 1'b0; Write = 1'b0; Read0 = 1'b0; Write0 = 1'b0;
      repeat (n) begin
         @(posedge Clock); #1;
      end
   endtask

   logic [15:0] q;
   int          w;
   logic [15:0] exp_v [3];

   initial begin
      exp_v[0] = 16'h0011; exp_v[1] = 16'h0022; exp_v[2] = 16'h0033;
      repeat (2) @(posedge Clock);
      #1 Reset = 1'b0;
      chk_en = 1'b1;
      @(negedge Clock);
      chk("rst_rddata", {16'b0, RdData}, 32'h0);
      chk("rst_ledr", {22'b0, LEDR}, 32'h0);
      chk("rst_error", {31'b0, Error}, 32'h0);
      chk("rst_waitreq", {31'b0, Waitreq}, 32'h0);
      @(posedge Clock); #1;

      // read after write
      xfer(0, 16'd5, 16'hBEEF, 0, 1, q, w);
      chk("wr5_waits", w, 3);
      idle(1);
      xfer(0, 16'd5, 16'h0000, 1, 0, q, w);
      chk("rd5_data", {16'b0, q}, 32'h0000BEEF);
      chk("rd5_waits", w, 3);
      idle(1);

      // I/O window
      xfer(0, 16'hFF00, 16'h03FF, 0, 1, q, w);
      chk("ledr_3ff", {22'b0, LEDR}, 32'h3FF);
      idle(1);
      SW = 10'h155;
      xfer(0, 16'hFF01, 16'h0, 1, 0, q, w);
      chk("rd_sw", {16'b0, q}, 32'h0155);
      idle(1);
      KEY = 4'hA;
      xfer(0, 16'hFF02, 16'h0, 1, 0, q, w);
      chk("rd_key", {16'b0, q}, 32'h000A);
      idle(1);
      xfer(0, 16'hFF07, 16'h0, 1, 0, q, w);
      chk("rd_hole", {16'b0, q}, 32'h0000);
      idle(1);

      // back-to-back reads, both wait-state settings
      for (int i = 0; i < 3; i++) begin
         xfer(0, 16'(i + 1), exp_v[i], 0, 1, q, w);
         xfer(1, 16'(i + 1), exp_v[i], 0, 1, q, w);
         idle(1);
      end
      for (int i = 0; i < 3; i++) begin
         xfer(0, 16'(i + 1), 16'h0, 1, 0, q, w);
         chk("b2b_data", {16'b0, q}, {16'b0, exp_v[i]});
         chk("b2b_waits", w, 3);
      end
      idle(1);
      for (int i = 0; i < 3; i++) begin
         xfer(1, 16'(i + 1), 16'h0, 1, 0, q, w);
         chk("b2b0_data", {16'b0, q}, {16'b0, exp_v[i]});
         chk("b2b0_waits", w, 2);
      end
      idle(1);

      // abort during BUSY
      xfer(0, 16'd9, 16'h5555, 0, 1, q, w);
      idle(1);
      Addr = 16'd9; WrData = 16'h1234; Write = 1'b1;
      @(posedge Clock); #1;
      Write = 1'b0;
      @(posedge Clock); #1;
      xfer(0, 16'd9, 16'h0, 1, 0, q, w);
      chk("abort_data", {16'b0, q}, 32'h5555);
      chk("abort_error", {31'b0, Error}, 32'h0);
      idle(1);

      // reset during BUSY of an LEDR write
      Addr = 16'hFF00; WrData = 16'h7777; Write = 1'b1;
      @(posedge Clock); #1;
      Reset = 1'b1;
      @(posedge Clock); #1;
      Reset = 1'b0; Write = 1'b0;
      @(negedge Clock);
      chk("rstmid_ledr", {22'b0, LEDR}, 32'h0);
      chk("rstmid_rddata", {16'b0, RdData}, 32'h0);
      chk("rstmid_waitreq_lo", {31'b0, Waitreq}, 32'h0);
      @(posedge Clock); #1;
      Addr = 16'd5; Read = 1'b1;
      @(negedge Clock);
      chk("rstmid_waitreq_hi", {31'b0, Waitreq}, 32'h1);
      @(posedge Clock); #1;
      idle(2);

      // simultaneous Read and Write
      xfer(0, 16'd4, 16'h00AA, 1, 1, q, w);
      chk("proto_error", {31'b0, Error}, 32'h1);
      idle(10);
      @(negedge Clock);
      chk("proto_sticky", {31'b0, Error}, 32'h1);
      @(posedge Clock); #1;
      xfer(0, 16'd4, 16'h0, 1, 0, q, w);
      chk("proto_ram4", {16'b0, q}, 32'h00AA);
      idle(1);
      Reset = 1'b1;
      @(posedge Clock); #1;
      Reset = 1'b0;
      @(negedge Clock);
      chk("proto_cleared", {31'b0, Error}, 32'h0);
      @(posedge Clock); #1;

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
